oclib_csr_arbiter: RTL and testbench
====================================

// Module: oclib_csr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one downstream csr_32 target between Requesters csr_32 masters.
//  Sits on the output side of oclib_csr_adapter, e.g. debug BC plus local CPU driving one register space.
//  Holds a grant for exactly one transaction, routes the response back to the granted master only,
//  and terminates with error if the target stays silent (TimeoutCycles).
// PARAMETERS
//  Requesters     2                        number of upstream masters, 2..16
//  TimeoutCycles  1024                     cycles to wait for outFb.ready before error completion; 0 = never time out
//  CsrType        oclib_pkg::csr_32_s      request type (up and down)
//  CsrFbType      oclib_pkg::csr_32_fb_s   feedback type (up and down)
// PORTS
//  clock    in   1                        single clock; all logic on posedge
//  reset    in   1                        synchronous, active-low (0 = in reset)
//  in       in   CsrType   [Requesters]   upstream requests (unpacked array)
//  inFb     out  CsrFbType [Requesters]   upstream responses
//  out      out  CsrType                  downstream request
//  outFb    in   CsrFbType                downstream response
//  grant    out  Requesters               one-hot current owner; 0 when idle
//  timeout  out  1                        one-cycle pulse when a transaction is error-terminated
// BEHAVIOUR
//  - Protocol: master holds read|write plus fields until it sees ready, then drops the request next cycle.
//    Response is {ready, error, rdata}; ready is a one-cycle pulse.
//  - Reset (reset==0): out = '0, inFb[*] = '0, grant = 0, timeout = 0, rrPtr = 0, timer = 0, FSM = IDLE.
//    Reset mid-transaction abandons it. No response is sent to the master, and a late outFb.ready is ignored.
//  - FSM IDLE -> ISSUE -> WAIT -> RELEASE -> IDLE.
//    IDLE: req[i] = in[i].read|in[i].write. Pick the first set req at or after rrPtr, with wrap-around.
//      On a hit: register grant (one-hot) and out <= in[g], then go to ISSUE. No hit: stay.
//    ISSUE/WAIT: out follows in[g] every cycle. Read and write are never both asserted, so forward as-is.
//      ISSUE is a single cycle; WAIT clears the timer to 0 on entry.
//    WAIT, outFb.ready=1: register inFb[g] <= outFb with ready=1, clear out.read/out.write, go to RELEASE.
//    WAIT, timer == TimeoutCycles-1 with no ready: inFb[g] <= {ready=1, error=1, rdata=0}, pulse timeout,
//      clear out.read/out.write, go to RELEASE.
//    RELEASE (1 cycle): inFb[*].ready = 0, grant = 0, rrPtr <= g+1 (mod Requesters), then IDLE.
//      outFb.ready here or in IDLE is ignored.
//  - Latency: request visible in IDLE at cycle N -> out valid at N+1.
//    outFb.ready at cycle M -> inFb[g].ready at M+1. The winner's next request is arbitrated no earlier than M+2.
//    Back-to-back throughput: one transaction per (target latency + 3) cycles.
//  - inFb[i] for i != g is always '0. Non-granted masters wait with their requests held.
//  - Simultaneous outFb.ready and timer expiry: ready wins, and the transaction completes normally with error = outFb.error.
//  - Master dropping its request while in WAIT is a protocol violation: the transaction completes anyway.
//  - timer width = $clog2(TimeoutCycles+1). It saturates and never wraps.
//  - Fairness: every requester is granted within Requesters transactions of asserting its request.
// STRUCTURE
//  - oclib_pkg: add enum csr_arb_state_e {IDLE, ISSUE, WAIT, RELEASE}.
//    Add localparam CsrArbMaxRequesters = 16.
//  - Sub-module oclib_rr_pick: combinational round-robin picker with ports req, ptr -> onehot, index, any.
//    It is reused by future fabric arbiters.
//  - OC_STATIC_ASSERT: Requesters in 2..16, and CsrType == csr_32_s.
// TESTING
//  1 Single read: in[0] reads addr 0x10, target answers ready with rdata 0xCAFE0001 after 3 cycles.
//    -> inFb[0].ready one cycle later with rdata 0xCAFE0001, grant=01 during the transaction, inFb[1] stays 0.
//  2 Contention: in[0] and in[1] both request at cycle 0, each reissues immediately when done.
//    -> grants alternate 01,10,01,10 over 4 transactions, and out never carries both.
//  3 Timeout: TimeoutCycles=8 and the target never answers.
//    -> 8 cycles in WAIT, then inFb[g] = {ready=1, error=1, rdata=0} and a single timeout pulse.
//    A late outFb.ready 2 cycles later is ignored.
//  4 Ready coincident with timeout: target answers on the last timer cycle with error=0, rdata=0x5.
//    -> normal completion with error=0, rdata=0x5, and no timeout pulse.
//  5 Reset mid-WAIT: reset=0 for 2 cycles during WAIT.
//    -> out='0, grant=0, rrPtr=0. The abandoned master gets no ready; after reset, requester 0 wins first.
//  6 Wrap: Requesters=4, rrPtr at 3, requests on 0 and 2.
//    -> grant 0001 (wrap-around), then 0100 next.

Source files
------------

// File: rtl/oclib_pkg.sv
// Shared CSR bus payload types and arbiter constants for the oclib register fabric.
package oclib_pkg;

  localparam int unsigned CsrAddrW            = 32;
  localparam int unsigned CsrDataW            = 32;
  localparam int unsigned CsrArbMaxRequesters = 16;

  typedef struct packed {
    logic                read;
    logic                write;
    logic [CsrAddrW-1:0] addr;
    logic [CsrDataW-1:0] wdata;
  } csr_32_s;

  typedef struct packed {
    logic                ready;
    logic                error;
    logic [CsrDataW-1:0] rdata;
  } csr_32_fb_s;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE
  } csr_arb_state_e;

endpackage

// File: rtl/oclib_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
module oclib_rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] index,
  output logic                 any
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned SumW = IdxW + 1;

  logic [SumW-1:0] sum;
  logic [IdxW-1:0] idx;

  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + SumW'(k);
      if (sum >= SumW'(N)) sum = sum - SumW'(N);
      idx = sum[IdxW-1:0];
      if (!any && req[idx]) begin
        onehot[idx] = 1'b1;
        index       = idx;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oclib_csr_arbiter.sv
// Round-robin arbiter sharing one csr_32 target between several masters, one transaction per grant,
// with error completion when the target stays silent for TimeoutCycles.
module oclib_csr_arbiter
  import oclib_pkg::*;
#(
  parameter int unsigned Requesters    = 2,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type         CsrType       = oclib_pkg::csr_32_s,
  parameter type         CsrFbType     = oclib_pkg::csr_32_fb_s
) (
  input  logic                  clock,
  input  logic                  reset,
  input  CsrType                in    [Requesters],
  output CsrFbType              inFb  [Requesters],
  output CsrType                out,
  input  CsrFbType              outFb,
  output logic [Requesters-1:0] grant,
  output logic                  timeout
);

  localparam int unsigned IdxW        = $clog2(Requesters);
  localparam int unsigned TimerW      = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam int unsigned TimeoutLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;

  // Elaboration-time parameter sanity checks
  if (Requesters < 2 || Requesters > CsrArbMaxRequesters) begin : g_bad_requesters
    $error("oclib_csr_arbiter: Requesters must be in 2..16");
  end
  if ($bits(CsrType) != $bits(csr_32_s)) begin : g_bad_csr_type
    $error("oclib_csr_arbiter: CsrType must be csr_32_s");
  end

  csr_arb_state_e        state_q, state_d;
  logic [Requesters-1:0] grant_q, grant_d;
  logic [IdxW-1:0]       gidx_q, gidx_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  CsrType                out_q, out_d;
  CsrFbType              infb_q [Requesters];
  CsrFbType              infb_d [Requesters];
  logic                  timeout_q, timeout_d;

  logic [Requesters-1:0] req_c;
  logic [Requesters-1:0] pick_onehot_c;
  logic [IdxW-1:0]       pick_index_c;
  logic                  pick_any_c;
  logic                  timer_expired_c;

  always_comb begin
    for (int unsigned i = 0; i < Requesters; i++) req_c[i] = in[i].read | in[i].write;
  end

  oclib_rr_pick #(.N(Requesters)) u_pick (
    .req    (req_c),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot_c),
    .index  (pick_index_c),
    .any    (pick_any_c)
  );

  // TimeoutCycles == 0 disables expiry; the timer then just saturates
  assign timer_expired_c = (TimeoutCycles != 0) && (timer_q == TimerW'(TimeoutLast));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;
    timer_d   = timer_q;
    out_d     = out_q;
    infb_d    = infb_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          grant_d = pick_onehot_c;
          gidx_d  = pick_index_c;
          out_d   = in[pick_index_c];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        out_d   = in[gidx_q];
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        out_d = in[gidx_q];
        // A ready arriving on the expiry cycle still completes normally
        if (outFb.ready) begin
          infb_d[gidx_q]       = outFb;
          infb_d[gidx_q].ready = 1'b1;
          out_d.read           = 1'b0;
          out_d.write          = 1'b0;
          state_d              = RELEASE;
        end else if (timer_expired_c) begin
          infb_d[gidx_q]       = '0;
          infb_d[gidx_q].ready = 1'b1;
          infb_d[gidx_q].error = 1'b1;
          out_d.read           = 1'b0;
          out_d.write          = 1'b0;
          timeout_d            = 1'b1;
          state_d              = RELEASE;
        end else if (timer_q != {TimerW{1'b1}}) begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      RELEASE: begin
        for (int unsigned i = 0; i < Requesters; i++) infb_d[i] = '0;
        grant_d  = '0;
        rr_ptr_d = (gidx_q == IdxW'(Requesters - 1)) ? '0 : gidx_q + IdxW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      timer_q   <= '0;
      out_q     <= '0;
      timeout_q <= 1'b0;
      for (int unsigned i = 0; i < Requesters; i++) infb_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      rr_ptr_q  <= rr_ptr_d;
      timer_q   <= timer_d;
      out_q     <= out_d;
      timeout_q <= timeout_d;
      for (int unsigned i = 0; i < Requesters; i++) infb_q[i] <= infb_d[i];
    end
  end

  assign out     = out_q;
  assign grant   = grant_q;
  assign timeout = timeout_q;
  assign inFb    = infb_q;

endmodule

// File: tb/tb_oclib_csr_arbiter.sv
// Self-checking bench for oclib_csr_arbiter: vector table, scoreboard queue and corner-case sequences.
module tb_oclib_csr_arbiter;
  import oclib_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  csr_32_s    a_in   [2];
  csr_32_fb_s a_infb [2];
  csr_32_s    a_out;
  csr_32_fb_s a_outfb;
  logic [1:0] a_grant;
  logic       a_tmo;
  csr_32_s    b_in   [4];
  csr_32_fb_s b_infb [4];
  csr_32_s    b_out;
  csr_32_fb_s b_outfb;
  logic [3:0] b_grant;
  logic       b_tmo;

  int errors = 0;
  int checks = 0;

  oclib_csr_arbiter #(.Requesters(2), .TimeoutCycles(8)) u_dut_a (
    .clock(clk), .reset(rst_n), .in(a_in), .inFb(a_infb), .out(a_out),
    .outFb(a_outfb), .grant(a_grant), .timeout(a_tmo)
  );

  oclib_csr_arbiter #(.Requesters(4), .TimeoutCycles(16)) u_dut_b (
    .clock(clk), .reset(rst_n), .in(b_in), .inFb(b_infb), .out(b_out),
    .outFb(b_outfb), .grant(b_grant), .timeout(b_tmo)
  );

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  typedef struct {
    int          m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [1:0]  exp_grant;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t a_q [$];
  exp_t mon_e;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit sel_b);
    int n;
    n = 0;
    while (!(sel_b ? (b_out.read | b_out.write) : (a_out.read | a_out.write)) && n < 40) begin
      tick();
      n++;
    end
    chk("out_valid", 128'(sel_b ? (b_out.read | b_out.write) : (a_out.read | a_out.write)), 128'(1));
  endtask

  task automatic respond(input bit sel_b, input int lat, input logic [31:0] rd, input logic er);
    repeat (lat) tick();
    if (sel_b) b_outfb = '{ready: 1'b1, error: er, rdata: rd};
    else       a_outfb = '{ready: 1'b1, error: er, rdata: rd};
    tick();
    a_outfb = '0;
    b_outfb = '0;
  endtask

  // Scoreboard: every upstream ready on DUT A must match the oldest expected completion
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("a_rw_both", 128'(a_out.read & a_out.write), 128'(0));
      chk("a_grant_onehot", 128'($countones(a_grant) <= 1), 128'(1));
      chk("b_grant_onehot", 128'($countones(b_grant) <= 1), 128'(1));
      chk("a_tmo_without_ready", 128'(a_tmo & ~(a_infb[0].ready | a_infb[1].ready)), 128'(0));
      for (int i = 0; i < 2; i++) begin
        if (a_infb[i].ready) begin
          if (a_q.size() == 0) begin
            chk("a_unexpected_ready", 128'(a_infb[i].ready), 128'(0));
          end else begin
            mon_e = a_q.pop_front();
            chk("a_resp_master", 128'(i), 128'(mon_e.m));
            chk("a_resp_rdata", 128'(a_infb[i].rdata), 128'(mon_e.rdata));
            chk("a_resp_error", 128'(a_infb[i].error), 128'(mon_e.err));
            chk("a_resp_timeout", 128'(a_tmo), 128'(mon_e.tmo));
            chk("a_resp_grant", 128'(a_grant), 128'(2'(1) << mon_e.m));
            chk("a_resp_other_fb", 128'(a_infb[1-i]), 128'(0));
          end
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 1'b0, 32'h10, 32'h0,        3, 32'hCAFE0001, 1'b0, 2'b01, 32'hCAFE0001, 1'b0};
    vecs[1] = '{1, 1'b1, 32'h20, 32'h12345678, 1, 32'h0,        1'b0, 2'b10, 32'h0,        1'b0};
    vecs[2] = '{0, 1'b0, 32'h44, 32'h0,        5, 32'hDEADBEEF, 1'b1, 2'b01, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{1, 1'b0, 32'h00, 32'h0,        2, 32'h0000A5A5, 1'b0, 2'b10, 32'h0000A5A5, 1'b0};

    rst_n   = 1'b0;
    a_outfb = '0;
    b_outfb = '0;
    for (int i = 0; i < 2; i++) a_in[i] = '0;
    for (int i = 0; i < 4; i++) b_in[i] = '0;
    tick();
    tick();
    chk("rst_a_out", 128'(a_out), 128'(0));
    chk("rst_a_grant", 128'(a_grant), 128'(0));
    chk("rst_a_tmo", 128'(a_tmo), 128'(0));
    chk("rst_a_fb0", 128'(a_infb[0]), 128'(0));
    chk("rst_a_fb1", 128'(a_infb[1]), 128'(0));
    chk("rst_b_out", 128'(b_out), 128'(0));
    chk("rst_b_grant", 128'(b_grant), 128'(0));
    rst_n = 1'b1;
    tick();

    // Single transactions from the vector table
    for (int v = 0; v < 4; v++) begin
      a_in[vecs[v].m] = '{read: !vecs[v].wr, write: vecs[v].wr, addr: vecs[v].addr, wdata: vecs[v].wdata};
      a_q.push_back('{m: vecs[v].m, rdata: vecs[v].exp_rdata, err: vecs[v].exp_err, tmo: 1'b0});
      tick();
      chk("vec_out_latency", 128'(a_out.read | a_out.write), 128'(1));
      wait_valid(1'b0);
      chk("vec_grant", 128'(a_grant), 128'(vecs[v].exp_grant));
      chk("vec_addr", 128'(a_out.addr), 128'(vecs[v].addr));
      chk("vec_write", 128'(a_out.write), 128'(vecs[v].wr));
      chk("vec_wdata", 128'(a_out.wdata), 128'(vecs[v].wdata));
      respond(1'b0, vecs[v].lat, vecs[v].rd, vecs[v].er);
      chk("vec_ready", 128'(a_infb[vecs[v].m].ready), 128'(1));
      chk("vec_other_fb", 128'(a_infb[1-vecs[v].m]), 128'(0));
      a_in[vecs[v].m] = '0;
      tick();
      chk("vec_ready_pulse", 128'(a_infb[vecs[v].m].ready), 128'(0));
      tick();
    end

    // Contention: both masters request together and reissue on completion
    a_in[0] = '{read: 1'b1, write: 1'b0, addr: 32'h100, wdata: 32'h0};
    a_in[1] = '{read: 1'b1, write: 1'b0, addr: 32'h200, wdata: 32'h0};
    for (int k = 0; k < 4; k++) a_q.push_back('{m: k % 2, rdata: 32'h1000 + k, err: 1'b0, tmo: 1'b0});
    for (int k = 0; k < 4; k++) begin
      wait_valid(1'b0);
      chk("rr_grant", 128'(a_grant), 128'(2'(1) << (k % 2)));
      chk("rr_addr", 128'(a_out.addr), 128'(((k % 2) ? 32'h200 : 32'h100) + 32'(4 * (k / 2))));
      respond(1'b0, 2, 32'h1000 + k, 1'b0);
      if (k < 2) a_in[k % 2].addr = a_in[k % 2].addr + 32'h4;
      else       a_in[k % 2] = '0;
    end
    repeat (3) tick();

    // Timeout: target never answers
    a_in[0] = '{read: 1'b1, write: 1'b0, addr: 32'h30, wdata: 32'h0};
    a_q.push_back('{m: 0, rdata: 32'h0, err: 1'b1, tmo: 1'b1});
    wait_valid(1'b0);
    repeat (8) tick();
    chk("to_not_early", 128'(a_infb[0].ready), 128'(0));
    chk("to_no_pulse_early", 128'(a_tmo), 128'(0));
    tick();
    chk("to_pulse", 128'(a_tmo), 128'(1));
    chk("to_fb", 128'(a_infb[0]), 128'({1'b1, 1'b1, 32'h0}));
    a_in[0] = '0;
    tick();
    chk("to_single_pulse", 128'(a_tmo), 128'(0));
    tick();
    a_outfb = '{ready: 1'b1, error: 1'b0, rdata: 32'hBAD};
    tick();
    a_outfb = '0;
    tick();
    chk("to_late_grant", 128'(a_grant), 128'(0));
    chk("to_late_fb", 128'(a_infb[0]), 128'(0));
    chk("to_late_out", 128'(a_out.read | a_out.write), 128'(0));

    // Ready coincident with the last timer cycle
    a_in[1] = '{read: 1'b1, write: 1'b0, addr: 32'h34, wdata: 32'h0};
    a_q.push_back('{m: 1, rdata: 32'h5, err: 1'b0, tmo: 1'b0});
    wait_valid(1'b0);
    respond(1'b0, 8, 32'h5, 1'b0);
    chk("co_tmo", 128'(a_tmo), 128'(0));
    chk("co_fb", 128'(a_infb[1]), 128'({1'b1, 1'b0, 32'h5}));
    a_in[1] = '0;
    repeat (2) tick();

    // Reset in WAIT: pointer returns to 0 and the abandoned master gets nothing
    a_in[0] = '{read: 1'b1, write: 1'b0, addr: 32'h40, wdata: 32'h0};
    a_q.push_back('{m: 0, rdata: 32'h77, err: 1'b0, tmo: 1'b0});
    wait_valid(1'b0);
    respond(1'b0, 1, 32'h77, 1'b0);
    a_in[0] = '0;
    repeat (2) tick();
    a_in[1] = '{read: 1'b1, write: 1'b0, addr: 32'h60, wdata: 32'h0};
    wait_valid(1'b0);
    chk("rst_pre_grant", 128'(a_grant), 128'(2'b10));
    repeat (2) tick();
    rst_n   = 1'b0;
    a_outfb = '{ready: 1'b1, error: 1'b0, rdata: 32'hBAD};
    tick();
    a_outfb = '0;
    tick();
    chk("rst_mid_out", 128'(a_out), 128'(0));
    chk("rst_mid_grant", 128'(a_grant), 128'(0));
    chk("rst_mid_fb1", 128'(a_infb[1]), 128'(0));
    chk("rst_mid_tmo", 128'(a_tmo), 128'(0));
    rst_n   = 1'b1;
    a_in[0] = '{read: 1'b1, write: 1'b0, addr: 32'h70, wdata: 32'h0};
    a_q.push_back('{m: 0, rdata: 32'h70, err: 1'b0, tmo: 1'b0});
    a_q.push_back('{m: 1, rdata: 32'h60, err: 1'b0, tmo: 1'b0});
    wait_valid(1'b0);
    chk("rst_first_grant", 128'(a_grant), 128'(2'b01));
    chk("rst_first_addr", 128'(a_out.addr), 128'(32'h70));
    respond(1'b0, 2, 32'h70, 1'b0);
    a_in[0] = '0;
    wait_valid(1'b0);
    chk("rst_second_grant", 128'(a_grant), 128'(2'b10));
    chk("rst_second_addr", 128'(a_out.addr), 128'(32'h60));
    respond(1'b0, 2, 32'h60, 1'b0);
    a_in[1] = '0;
    repeat (3) tick();

    // Wrap-around with four requesters: move the pointer to 3 first
    b_in[2] = '{read: 1'b1, write: 1'b0, addr: 32'h222, wdata: 32'h0};
    wait_valid(1'b1);
    chk("wrap_setup_grant", 128'(b_grant), 128'(4'b0100));
    respond(1'b1, 1, 32'h2, 1'b0);
    chk("wrap_setup_fb", 128'(b_infb[2]), 128'({1'b1, 1'b0, 32'h2}));
    b_in[2] = '0;
    repeat (2) tick();
    b_in[0] = '{read: 1'b1, write: 1'b0, addr: 32'hA00, wdata: 32'h0};
    b_in[2] = '{read: 1'b1, write: 1'b0, addr: 32'hA02, wdata: 32'h0};
    wait_valid(1'b1);
    chk("wrap_grant0", 128'(b_grant), 128'(4'b0001));
    chk("wrap_addr0", 128'(b_out.addr), 128'(32'hA00));
    respond(1'b1, 1, 32'hA0, 1'b0);
    chk("wrap_fb0", 128'(b_infb[0]), 128'({1'b1, 1'b0, 32'hA0}));
    chk("wrap_fb2_quiet", 128'(b_infb[2]), 128'(0));
    b_in[0] = '0;
    wait_valid(1'b1);
    chk("wrap_grant2", 128'(b_grant), 128'(4'b0100));
    chk("wrap_addr2", 128'(b_out.addr), 128'(32'hA02));
    respond(1'b1, 1, 32'hA2, 1'b0);
    chk("wrap_fb2", 128'(b_infb[2]), 128'({1'b1, 1'b0, 32'hA2}));
    chk("wrap_b_tmo", 128'(b_tmo), 128'(0));
    b_in[2] = '0;
    repeat (3) tick();

    chk("a_scoreboard_drained", 128'(a_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
